// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: widths, opcode encodings,
// FSM state type, word stride and small opcode decode helpers.
package mau_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int NREG   = 8;

    localparam logic [1:0] OP_LW = 2'd0;
    localparam logic [1:0] OP_SW = 2'd1;
    localparam logic [1:0] OP_LM = 2'd2;
    localparam logic [1:0] OP_SM = 2'd3;

    // One 16-bit word spans two byte addresses.
    localparam logic [ADDR_W-1:0] WORD_STRIDE = 16'd2;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Loads (LW/LM) read memory and write the register file.
    function automatic logic is_load_op(input logic [1:0] op);
        return (op == OP_LW) || (op == OP_LM);
    endfunction

    // Multi-register ops (LM/SM) take their register list from the mask.
    function automatic logic is_multi_op(input logic [1:0] op);
        return (op == OP_LM) || (op == OP_SM);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of pipeline request, register-file and data-memory signals of the
// memory access unit. "master" is the unit itself, "slave" is its environment
// (pipeline, register file and memory).
interface mem_access_unit_if;
    import mau_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_base;
    logic [NREG-1:0]   req_mask;
    logic [2:0]        req_rd;
    logic [DATA_W-1:0] req_wdata;

    logic [2:0]        rf_rd_idx;
    logic [DATA_W-1:0] rf_rd_data;
    logic              rf_wr_en;
    logic [2:0]        rf_wr_idx;
    logic [DATA_W-1:0] rf_wr_data;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] dm_data;

    logic              done;
    logic              misalign_err;

    modport master (
        input  req_valid, req_op, req_base, req_mask, req_rd, req_wdata,
        input  rf_rd_data, dm_data,
        output req_ready, rf_rd_idx, rf_wr_en, rf_wr_idx, rf_wr_data,
        output addr, write_data, MemRead, MemWrite, done, misalign_err
    );

    modport slave (
        output req_valid, req_op, req_base, req_mask, req_rd, req_wdata,
        output rf_rd_data, dm_data,
        input  req_ready, rf_rd_idx, rf_wr_en, rf_wr_idx, rf_wr_data,
        input  addr, write_data, MemRead, MemWrite, done, misalign_err
    );

endinterface

// File: rtl/lowest_set_bit8.sv
// Combinational priority encoder: index of the lowest set bit of an 8-bit
// mask, plus a flag that is high when exactly one bit is set.
module lowest_set_bit8 (
    input  logic [7:0] mask,
    output logic [2:0] idx,
    output logic       last
);

    // Scan from the top down so the lowest set bit wins; isolate one-hot masks.
    always_comb begin
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        last = (mask != 8'd0) && ((mask & (mask - 8'd1)) == 8'd0);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: LW/SW move one word, LM/SM walk an 8-bit
// register mask in ascending order, one 16-bit word per cycle.
// Optional build macro: LSU_ALIGN_CHECK_EN rejects odd base addresses with a
// done + misalign_err pulse instead of performing any transfer.
module mem_access_unit
    import mau_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.master bus
);

    state_t            state_r;
    logic [1:0]        op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [NREG-1:0]   mask_r;
    logic [2:0]        rd_r;
    logic [DATA_W-1:0] wdata_r;
    logic              done_r;
    logic              misalign_r;

    logic [2:0]        cur_idx_s;
    logic              last_s;
    logic              misalign_s;

    logic [2:0]        rf_rd_idx_s;
    logic              rf_wr_en_s;
    logic [2:0]        rf_wr_idx_s;
    logic [DATA_W-1:0] rf_wr_data_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] write_data_s;
    logic              mem_read_s;
    logic              mem_write_s;

    lowest_set_bit8 u_lsb (
        .mask (mask_r),
        .idx  (cur_idx_s),
        .last (last_s)
    );

`ifdef LSU_ALIGN_CHECK_EN
    assign misalign_s = bus.req_base[0];
`else
    assign misalign_s = 1'b0;
`endif

    // Request acceptance, per-word sequencing and the done/error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            op_r       <= OP_LW;
            addr_r     <= '0;
            mask_r     <= '0;
            rd_r       <= 3'd0;
            wdata_r    <= '0;
            done_r     <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r     <= 1'b0;
                    misalign_r <= 1'b0;
                    if (bus.req_valid) begin
                        op_r    <= bus.req_op;
                        addr_r  <= bus.req_base;
                        rd_r    <= bus.req_rd;
                        wdata_r <= bus.req_wdata;
                        if (misalign_s) begin
                            done_r     <= 1'b1;
                            misalign_r <= 1'b1;
                        end else if (is_multi_op(bus.req_op)) begin
                            if (bus.req_mask == 8'd0) begin
                                done_r <= 1'b1;
                            end else begin
                                mask_r  <= bus.req_mask;
                                state_r <= XFER;
                            end
                        end else begin
                            // Single-word ops reuse the mask walker with one pseudo-bit.
                            mask_r  <= 8'h01;
                            state_r <= XFER;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                XFER: begin
                    mask_r <= mask_r & (mask_r - 8'd1);
                    addr_r <= addr_r + WORD_STRIDE;
                    if (last_s) begin
                        state_r <= IDLE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= XFER;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Memory and register-file strobes for the word currently being moved.
    always_comb begin
        rf_rd_idx_s  = 3'd0;
        rf_wr_en_s   = 1'b0;
        rf_wr_idx_s  = 3'd0;
        rf_wr_data_s = '0;
        addr_s       = '0;
        write_data_s = '0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        if (state_r == XFER) begin
            addr_s      = addr_r;
            rf_rd_idx_s = cur_idx_s;
            if (is_load_op(op_r)) begin
                mem_read_s   = 1'b1;
                rf_wr_en_s   = 1'b1;
                rf_wr_data_s = bus.dm_data;
                rf_wr_idx_s  = (op_r == OP_LW) ? rd_r : cur_idx_s;
            end else begin
                mem_write_s  = 1'b1;
                write_data_s = (op_r == OP_SW) ? wdata_r : bus.rf_rd_data;
            end
        end else begin
            addr_s = '0;
        end
    end

    assign bus.req_ready    = (state_r == IDLE);
    assign bus.done         = done_r;
    assign bus.misalign_err = misalign_r;
    assign bus.rf_rd_idx    = rf_rd_idx_s;
    assign bus.rf_wr_en     = rf_wr_en_s;
    assign bus.rf_wr_idx    = rf_wr_idx_s;
    assign bus.rf_wr_data   = rf_wr_data_s;
    assign bus.addr         = addr_s;
    assign bus.write_data   = write_data_s;
    assign bus.MemRead      = mem_read_s;
    assign bus.MemWrite     = mem_write_s;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected
// memory/register-file events with their cycle numbers; a negedge monitor
// pops and compares every cycle in which the unit shows activity.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam int K_READ  = 0;
    localparam int K_WRITE = 1;
    localparam int K_DONE  = 2;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
        logic [2:0]  idx;
        logic        mis;
        int          at;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0]  mem [0:65535];
    logic [15:0] rf  [0:7];
    logic [15:0] addr_p1;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign addr_p1        = bus.addr + 16'd1;
    assign bus.dm_data    = {mem[addr_p1], mem[bus.addr]};
    assign bus.rf_rd_data = rf[bus.rf_rd_idx];

    always @(posedge clk) begin
        if (bus.MemWrite) begin
            mem[bus.addr] <= bus.write_data[7:0];
            mem[addr_p1]  <= bus.write_data[15:8];
        end
        if (bus.rf_wr_en) rf[bus.rf_wr_idx] <= bus.rf_wr_data;
    end

    // Monitor: one scoreboard entry per active cycle.
    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (rst && (bus.MemRead || bus.MemWrite || bus.done || bus.misalign_err)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_activity: cyc=%0d rd=%b wr=%b done=%b mis=%b addr=%h, required no activity",
                         cyc, bus.MemRead, bus.MemWrite, bus.done, bus.misalign_err, bus.addr);
            end else begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_READ:  ok = bus.MemRead && !bus.MemWrite && bus.rf_wr_en && !bus.done &&
                                  bus.addr == e.addr && bus.rf_wr_idx == e.idx &&
                                  bus.rf_wr_data == e.data && cyc == e.at;
                    K_WRITE: ok = bus.MemWrite && !bus.MemRead && !bus.rf_wr_en && !bus.done &&
                                  bus.addr == e.addr && bus.write_data == e.data && cyc == e.at;
                    default: ok = bus.done && !bus.MemRead && !bus.MemWrite && bus.req_ready &&
                                  bus.misalign_err == e.mis && cyc == e.at;
                endcase
                if (!ok) begin
                    n_bad++;
                    $display("FAIL %s: got cyc=%0d rd=%b wr=%b wen=%b done=%b mis=%b rdy=%b addr=%h wdata=%h rfidx=%0d rfdata=%h; required cyc=%0d addr=%h data=%h idx=%0d mis=%b",
                             e.name, cyc, bus.MemRead, bus.MemWrite, bus.rf_wr_en, bus.done,
                             bus.misalign_err, bus.req_ready, bus.addr, bus.write_data,
                             bus.rf_wr_idx, bus.rf_wr_data, e.at, e.addr, e.data, e.idx, e.mis);
                end
            end
        end
    end

    task automatic push(input string name, input int kind, input logic [15:0] a,
                        input logic [15:0] d, input logic [2:0] idx, input logic mis, input int at);
        exp_t e;
        e.name = name; e.kind = kind; e.addr = a; e.data = d;
        e.idx = idx; e.mis = mis; e.at = at;
        exp_q.push_back(e);
    endtask

    // Present a request; returns N = cycle count before the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [15:0] base, input logic [7:0] mask,
                         input logic [2:0] rd, input logic [15:0] wd, output int n);
        logic rdy;
        int   budget;
        budget = 0;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_base = base;
        bus.req_mask = mask; bus.req_rd = rd; bus.req_wdata = wd;
        do begin
            rdy = bus.req_ready;
            @(posedge clk); #1;
            budget++;
        end while (!rdy && budget < 50);
        bus.req_valid = 1'b0;
        n = cyc - 1;
        if (!rdy) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: req_ready=0 after %0d cycles, required 1", budget);
        end
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d events outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        int n;
        int n2;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12;
        mem[16'h0031] = 8'h78; mem[16'h0032] = 8'h56;
        mem[16'hFFFE] = 8'h22; mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h44; mem[16'h0001] = 8'h33;
        rf[0] = 16'h1100; rf[1] = 16'h2211; rf[2] = 16'h3322; rf[3] = 16'h4433;
        rf[4] = 16'h5544; rf[5] = 16'h6655; rf[6] = 16'h7766; rf[7] = 16'h8877;
        bus.req_valid = 1'b0; bus.req_op = 2'd0; bus.req_base = 16'h0000;
        bus.req_mask = 8'h00; bus.req_rd = 3'd0; bus.req_wdata = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (!(bus.req_ready && !bus.done && !bus.misalign_err && !bus.MemRead && !bus.MemWrite &&
              !bus.rf_wr_en && bus.addr == 16'h0 && bus.write_data == 16'h0 && bus.rf_wr_data == 16'h0)) begin
            n_bad++;
            $display("FAIL reset_state: rdy=%b done=%b mis=%b rd=%b wr=%b wen=%b addr=%h, required rdy=1 rest 0",
                     bus.req_ready, bus.done, bus.misalign_err, bus.MemRead, bus.MemWrite, bus.rf_wr_en, bus.addr);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // LW 0x0010 -> R3 = 0x1234
        issue(2'd0, 16'h0010, 8'h00, 3'd3, 16'h0000, n);
        push("lw_read", K_READ, 16'h0010, 16'h1234, 3'd3, 1'b0, n + 1);
        push("lw_done", K_DONE, 16'h0, 16'h0, 3'd0, 1'b0, n + 2);
        wait_drain();

        // SW 0xBEEF to 0x0020 then back-to-back LW into R4
        issue(2'd1, 16'h0020, 8'h00, 3'd0, 16'hBEEF, n);
        push("sw_write", K_WRITE, 16'h0020, 16'hBEEF, 3'd0, 1'b0, n + 1);
        push("sw_done", K_DONE, 16'h0, 16'h0, 3'd0, 1'b0, n + 2);
        issue(2'd0, 16'h0020, 8'h00, 3'd4, 16'h0000, n2);
        n_cmp++;
        if (n2 != n + 2) begin
            n_bad++;
            $display("FAIL back_to_back_accept: accepted at %0d, required %0d", n2, n + 2);
        end
        push("lw2_read", K_READ, 16'h0020, 16'hBEEF, 3'd4, 1'b0, n2 + 1);
        push("lw2_done", K_DONE, 16'h0, 16'h0, 3'd0, 1'b0, n2 + 2);
        wait_drain();

        // SM mask 0xA5 at 0x0100: R0, R2, R5, R7
        issue(2'd3, 16'h0100, 8'hA5, 3'd0, 16'h0000, n);
        push("sm_r0", K_WRITE, 16'h0100, 16'h1100, 3'd0, 1'b0, n + 1);
        push("sm_r2", K_WRITE, 16'h0102, 16'h3322, 3'd0, 1'b0, n + 2);
        push("sm_r5", K_WRITE, 16'h0104, 16'h6655, 3'd0, 1'b0, n + 3);
        push("sm_r7", K_WRITE, 16'h0106, 16'h8877, 3'd0, 1'b0, n + 4);
        push("sm_done", K_DONE, 16'h0, 16'h0, 3'd0, 1'b0, n + 5);
        wait_drain();

        // LM empty mask: done next cycle, req_ready stays high
        issue(2'd2, 16'h0300, 8'h00, 3'd0, 16'h0000, n);
        push("lm0_done", K_DONE, 16'h0, 16'h0, 3'd0, 1'b0, n + 1);
        n_cmp++;
        if (!bus.req_ready) begin
            n_bad++;
            $display("FAIL lm0_ready: req_ready=%b, required 1", bus.req_ready);
        end
        wait_drain();

        // LM mask 0x03 at 0xFFFE wraps to 0x0000
        issue(2'd2, 16'hFFFE, 8'h03, 3'd0, 16'h0000, n);
        push("lm_wrap_r0", K_READ, 16'hFFFE, 16'h1122, 3'd0, 1'b0, n + 1);
        push("lm_wrap_r1", K_READ, 16'h0000, 16'h3344, 3'd1, 1'b0, n + 2);
        push("lm_wrap_done", K_DONE, 16'h0, 16'h0, 3'd0, 1'b0, n + 3);
        wait_drain();

`ifdef LSU_ALIGN_CHECK_EN
        // Odd base rejected
        issue(2'd0, 16'h0011, 8'h00, 3'd2, 16'h0000, n);
        push("misalign_done", K_DONE, 16'h0, 16'h0, 3'd0, 1'b1, n + 1);
        wait_drain();
`else
        // Odd base used as given
        issue(2'd0, 16'h0031, 8'h00, 3'd2, 16'h0000, n);
        push("odd_lw_read", K_READ, 16'h0031, 16'h5678, 3'd2, 1'b0, n + 1);
        push("odd_lw_done", K_DONE, 16'h0, 16'h0, 3'd0, 1'b0, n + 2);
        wait_drain();
`endif

        // SM mask 0xFF at 0x0200, reset during second transfer
        issue(2'd3, 16'h0200, 8'hFF, 3'd0, 16'h0000, n);
        push("rst_sm_r0", K_WRITE, 16'h0200, 16'h1122, 3'd0, 1'b0, n + 1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (!(!bus.MemWrite && !bus.MemRead && !bus.rf_wr_en && bus.req_ready && !bus.done && bus.addr == 16'h0)) begin
            n_bad++;
            $display("FAIL reset_mid_xfer: wr=%b rd=%b wen=%b rdy=%b done=%b addr=%h, required strobes 0 rdy 1",
                     bus.MemWrite, bus.MemRead, bus.rf_wr_en, bus.req_ready, bus.done, bus.addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (!(mem[16'h0200] == 8'h22 && mem[16'h0201] == 8'h11 &&
              mem[16'h0202] == 8'h00 && mem[16'h0203] == 8'h00 && exp_q.size() == 0)) begin
            n_bad++;
            $display("FAIL reset_mem_contents: [0200..0203]=%h %h %h %h pending=%0d, required 22 11 00 00 pending=0",
                     mem[16'h0200], mem[16'h0201], mem[16'h0202], mem[16'h0203], exp_q.size());
        end

        wait_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Pipeline-side initiator for the byte-addressed, 16-bit data memory port in the MEM stage. Accepts one load/store request at a time from the pipeline: single-word LW/SW or multi-register LM/SM driven by an 8-bit register mask. Sequences one memory word per cycle on addr/write_data/MemRead/MemWrite, and returns load data to the register file. Holds req_ready low while sequencing, which the pipeline uses as its stall.

## Interface
- ADDR_W, 16, memory address width (byte address)
- DATA_W, 16, word width; one word occupies bytes addr and addr+1, little-endian
- NREG, 8, register count and LM/SM mask width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle and able to accept
- req_op  in  2  0=LW, 1=SW, 2=LM, 3=SM
- req_base  in  ADDR_W  base byte address
- req_mask  in  NREG  LM/SM register mask; bit i selects register i
- req_rd  in  3  LW destination register
- req_wdata  in  DATA_W  SW store data
- rf_rd_idx  out  3  register-file read index, used for SM
- rf_rd_data  in  DATA_W  combinational register-file read data
- rf_wr_en  out  1  register-file write strobe
- rf_wr_idx  out  3  register-file write index
- rf_wr_data  out  DATA_W  register-file write data, driven from dm_data
- addr  out  ADDR_W  memory address
- write_data  out  DATA_W  memory write data
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable; memory commits on the rising edge
- dm_data  in  DATA_W  combinational memory read data
- done  out  1  one-cycle pulse when a request completes
- misalign_err  out  1  one-cycle pulse when a request is rejected (see Configuration)

## Operation
- FSM has two states, IDLE and XFER. Registered state: op_q, addr_q, mask_q, rd_q, wdata_q.
- req_ready = (state==IDLE). A request is accepted on the edge where req_valid & req_ready are both high.
- On accept with LW/SW:
  - load mask_q with a single pseudo-bit.
  - go to XFER.
- On accept with LM/SM and nonzero mask: go to XFER.
- On accept with LM/SM and req_mask==0: stay in IDLE, perform no memory access, and pulse done next cycle.
- XFER performs one transfer per cycle on the lowest set bit of mask_q:
  - LW/LM: MemRead=1, addr=addr_q, rf_wr_en=1, rf_wr_data=dm_data. rf_wr_idx = rd_q for LW, or the current bit index for LM.
  - SW/SM: MemWrite=1, addr=addr_q, write_data = wdata_q for SW, or rf_rd_data for SM. rf_rd_idx = current bit index.
  - Each edge clears the processed bit and sets addr_q += 2, modulo 2^ADDR_W (0xFFFE wraps to 0x0000).
  - On the last set bit, return to IDLE and set done for the next cycle.
- Registers are visited in ascending index order.
- Outside XFER: MemRead, MemWrite, rf_wr_en = 0; addr, write_data, rf_wr_data = 0.
- Never assert MemRead and MemWrite together.
- req_* inputs are ignored while in XFER.

## Timing
- Reset values: state=IDLE, req_ready=1, done=0, misalign_err=0. All memory and register-file strobes are 0; all data and address outputs are 0.
- Request accepted at edge N with k set bits (k=1 for LW/SW):
  - transfers occupy cycles N+1 … N+k.
  - done is high in cycle N+k+1, with req_ready=1 in the same cycle.
- Back-to-back operation: a new request may be accepted at the edge ending the done cycle, giving zero idle cycles.
- Empty-mask LM/SM: done is high in cycle N+1; no strobes.
- Reset asserted mid-XFER: immediately returns to IDLE and clears all strobes. Words already written stay written; remaining transfers are dropped; no done pulse.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - an accepted request with req_base[0]==1 performs no transfer.
  - done and misalign_err pulse together in cycle N+1.
- LSU_ALIGN_CHECK_EN undefined:
  - misalign_err is tied to 0.
  - any base is used as given; odd addresses still step by 2.

## Structure
- Shared package mau_pkg holds:
  - op encodings: OP_LW, OP_SW, OP_LM, OP_SM.
  - state enum: IDLE, XFER.
  - the word stride constant: 2.
- One sub-module, lowest_set_bit8: maps an 8-bit mask to a 3-bit index plus a last-bit flag (mask has exactly one bit set). It is purely combinational.

## Test plan
- LW: base 0x0010, rd=3, memory[0x0010..11]=0x34,0x12 → cycle N+1 has MemRead=1, addr=0x0010, rf_wr_en=1, idx 3, data 0x1234; done in N+2.
- SW then LW: SW 0xBEEF to 0x0020, then LW from 0x0020 → store completes in one cycle; the load returns 0xBEEF; the second request is accepted in the first request's done cycle.
- SM with mask 0xA5, base 0x0100 → writes R0, R2, R5, R7 to 0x0100, 0x0102, 0x0104, 0x0106 in four consecutive cycles; done in N+5.
- LM with mask 0x00 → no MemRead/MemWrite; done in N+1; req_ready never drops.
- LM with mask 0x03, base 0xFFFE → accesses 0xFFFE then 0x0000 (wrap).
- Reset dropped in the second cycle of SM with mask 0xFF → only R0 is written; all strobes are 0 immediately; req_ready=1; no done. With LSU_ALIGN_CHECK_EN defined, base 0x0011 → no strobes; done and misalign_err both high in N+1.
